// File: rtl/period_meter_pkg.sv
// Shared types and default timing constants for the period meter.
// The defaults assume a 50 MHz clk_in and a 50 Hz .. 2 kHz pitch range.
package period_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH      = 20;
  localparam int DEFAULT_MIN_PERIOD = 25000;
  localparam int DEFAULT_MAX_PERIOD = 1000000;
  localparam int DEFAULT_AVG_LOG2   = 2;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Two-flop synchronizer for the asynchronous pitch input plus rising-edge detect.
// Everything clears to 0 on reset, so the detector starts from a known low level.
module edge_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic d_async,
  output logic rise
);

  logic meta;
  logic synced;
  logic prev;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= d_async;
      synced <= meta;
      prev   <= synced;
    end
  end

  assign rise = synced & ~prev;

endmodule

// File: rtl/period_meter.sv
// Measures the period of a slow square wave in clk_in cycles, averaging
// 2^AVG_LOG2 periods per result, rejecting glitch edges and flagging loss of signal.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MIN_PERIOD = DEFAULT_MIN_PERIOD,
  parameter int MAX_PERIOD = DEFAULT_MAX_PERIOD,
  parameter int AVG_LOG2   = DEFAULT_AVG_LOG2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             no_signal
);

  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] MAX_P = WIDTH'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] AVG_N = CNT_W'(1 << AVG_LOG2);

  state_t             state;
  state_t             next_state;
  logic               rise;
  logic               timeout;
  logic               start;
  logic               accept;
  logic [WIDTH-1:0]   counter;
  logic [WIDTH-1:0]   counter_next;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   avg_cnt;
  logic [CNT_W-1:0]   avg_next;
  logic [WIDTH-1:0]   period_next;
  logic               valid_next;
  logic               no_signal_next;

  edge_sync u_edge_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .d_async (sig_in),
    .rise    (rise)
  );

  // A timeout outranks a coincident rise; that rise then restarts measurement.
  assign timeout = (state == MEASURE) && (counter == MAX_P);
  assign start   = rise && ((state == IDLE) || timeout);
  assign accept  = (state == MEASURE) && rise && !timeout && (counter >= MIN_P);
  assign acc_sum = acc + ACC_W'(counter);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rise) begin
          next_state = MEASURE;
        end
      end
      MEASURE: begin
        if (timeout) begin
          next_state = start ? MEASURE : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    counter_next   = (counter == MAX_P) ? MAX_P : counter + WIDTH'(1);
    acc_next       = acc;
    avg_next       = avg_cnt;
    period_next    = period;
    valid_next     = 1'b0;
    no_signal_next = no_signal;

    if (start || accept) begin
      counter_next = WIDTH'(1);
    end

    if (timeout) begin
      period_next    = '0;
      no_signal_next = 1'b1;
      acc_next       = '0;
      avg_next       = '0;
    end else if (start) begin
      acc_next = '0;
      avg_next = '0;
    end else if (accept) begin
      if (avg_cnt + CNT_W'(1) == AVG_N) begin
        period_next    = WIDTH'(acc_sum >> AVG_LOG2);
        valid_next     = 1'b1;
        no_signal_next = 1'b0;
        acc_next       = '0;
        avg_next       = '0;
      end else begin
        acc_next = acc_sum;
        avg_next = avg_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      counter      <= '0;
      acc          <= '0;
      avg_cnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      no_signal    <= 1'b1;
    end else begin
      counter      <= counter_next;
      acc          <= acc_next;
      avg_cnt      <= avg_next;
      period       <= period_next;
      period_valid <= valid_next;
      no_signal    <= no_signal_next;
    end
  end

  strobe_single_cycle: assert property (
    @(posedge clk_in) disable iff (rst) period_valid |=> !period_valid
  );

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus queues expected strobes,
// a negedge monitor pops and compares each strobe as the DUT presents it.
module tb_period_meter;

  localparam int WIDTH      = 8;
  localparam int MIN_PERIOD = 4;
  localparam int MAX_PERIOD = 100;
  localparam int AVG_LOG2   = 1;

  typedef struct {
    int period;
    int gap;
  } exp_t;

  logic             clk_in;
  logic             rst;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             no_signal;

  exp_t sb_queue[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   last_strobe = 0;
  logic prev_valid = 1'b0;

  period_meter #(
    .WIDTH      (WIDTH),
    .MIN_PERIOD (MIN_PERIOD),
    .MAX_PERIOD (MAX_PERIOD),
    .AVG_LOG2   (AVG_LOG2)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .sig_in       (sig_in),
    .period       (period),
    .period_valid (period_valid),
    .no_signal    (no_signal)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input int hi, input int lo);
    sig_in = 1'b1;
    waitCycles(hi);
    sig_in = 1'b0;
    waitCycles(lo);
  endtask

  // One period of 20 with an extra rise 2 cycles after the real one.
  task automatic applyGlitchWave();
    sig_in = 1'b1;
    waitCycles(1);
    sig_in = 1'b0;
    waitCycles(1);
    sig_in = 1'b1;
    waitCycles(2);
    sig_in = 1'b0;
    waitCycles(16);
  endtask

  task automatic expectStrobe(input int p, input int gap);
    exp_t e;
    e.period = p;
    e.gap    = gap;
    sb_queue.push_back(e);
  endtask

  // Monitor: every strobe must match the next queued expectation.
  always @(negedge clk_in) begin
    if (period_valid) begin
      checkOutput("strobe_width", int'(prev_valid), 0);
      if (sb_queue.size() == 0) begin
        checkOutput("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = sb_queue.pop_front();
        checkOutput("strobe_period", int'(period), e.period);
        checkOutput("strobe_no_signal", int'(no_signal), 0);
        if (e.gap != 0) begin
          checkOutput("strobe_gap", cycle - last_strobe, e.gap);
        end
      end
      last_strobe = cycle;
    end
    prev_valid = period_valid;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int target;
    rst    = 1'b1;
    sig_in = 1'b0;

    $display("[TB] reset with toggling input");
    for (int i = 0; i < 3; i++) begin
      sig_in = ~sig_in;
      waitCycles(1);
    end
    sig_in = 1'b0;
    rst    = 1'b0;
    checkOutput("reset_period", int'(period), 0);
    checkOutput("reset_valid", int'(period_valid), 0);
    checkOutput("reset_no_signal", int'(no_signal), 1);
    for (int i = 0; i < 5; i++) begin
      waitCycles(1);
      checkOutput("post_reset_valid", int'(period_valid), 0);
    end

    $display("[TB] steady period 20");
    expectStrobe(20, 0);
    expectStrobe(20, 40);
    expectStrobe(20, 40);
    for (int i = 0; i < 7; i++) applyStimulus(10, 10);
    checkOutput("steady_period", int'(period), 20);
    checkOutput("steady_no_signal", int'(no_signal), 0);
    waitCycles(120);
    checkOutput("idle_period", int'(period), 0);
    checkOutput("idle_no_signal", int'(no_signal), 1);

    $display("[TB] alternating periods 18/22 then 19/20");
    expectStrobe(20, 0);
    expectStrobe(20, 40);
    expectStrobe(19, 39);
    expectStrobe(19, 39);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(9, 9);
      applyStimulus(11, 11);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(10, 9);
      applyStimulus(10, 10);
    end
    applyStimulus(10, 10);
    checkOutput("truncated_period", int'(period), 19);
    waitCycles(120);

    $display("[TB] glitch rejection");
    expectStrobe(20, 0);
    expectStrobe(20, 40);
    expectStrobe(20, 40);
    applyStimulus(10, 10);
    applyStimulus(10, 10);
    applyGlitchWave();
    applyStimulus(10, 10);
    applyGlitchWave();
    applyStimulus(10, 10);
    applyStimulus(10, 10);
    checkOutput("glitch_period", int'(period), 20);

    $display("[TB] loss of signal and restart");
    target = last_strobe + 99;
    while (cycle < target) @(negedge clk_in);
    checkOutput("pre_timeout_no_signal", int'(no_signal), 0);
    checkOutput("pre_timeout_period", int'(period), 20);
    @(negedge clk_in);
    checkOutput("timeout_no_signal", int'(no_signal), 1);
    checkOutput("timeout_period", int'(period), 0);
    expectStrobe(20, 0);
    for (int i = 0; i < 3; i++) applyStimulus(10, 10);
    checkOutput("restart_period", int'(period), 20);
    checkOutput("restart_no_signal", int'(no_signal), 0);
    waitCycles(120);

    $display("[TB] reset in the middle of an averaging pair");
    expectStrobe(20, 0);
    expectStrobe(30, 0);
    for (int i = 0; i < 3; i++) applyStimulus(10, 10);
    sig_in = 1'b1;
    waitCycles(10);
    sig_in = 1'b0;
    waitCycles(4);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    checkOutput("midreset_period", int'(period), 0);
    checkOutput("midreset_no_signal", int'(no_signal), 1);
    checkOutput("midreset_valid", int'(period_valid), 0);
    waitCycles(6);
    applyStimulus(15, 15);
    applyStimulus(15, 15);
    applyStimulus(10, 10);
    checkOutput("post_reset_period", int'(period), 30);
    waitCycles(120);

    checkOutput("scoreboard_drained", sb_queue.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
